// File: rtl/neo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neo_pkg - shared FSM type and channel transmit order (rev 1.0)
// ----------------------------------------------------------------------------
package neo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam logic [1:0] CH_W = 2'd3;

  // Wire order within a pixel is G, R, B, W.
  function automatic logic [1:0] tx_channel(input logic [1:0] slot);
    logic [1:0] ch;
    case (slot)
      2'd0:    ch = CH_G;
      2'd1:    ch = CH_R;
      2'd2:    ch = CH_B;
      default: ch = CH_W;
    endcase
    return ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neo_bit_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neo_bit_encoder - one NeoPixel bit period with programmable high time (rev 1.0)
// ----------------------------------------------------------------------------
module neo_bit_encoder #(
  parameter int T0H_CYC  = 18,
  parameter int T1H_CYC  = 35,
  parameter int TBIT_CYC = 63
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic bit_val,
  output logic wave,
  output logic bit_done
);

  localparam int CW = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] C_T0H  = CW'(T0H_CYC);
  localparam logic [CW-1:0] C_T1H  = CW'(T1H_CYC);

  logic          active;
  logic [CW-1:0] cnt;

  // A start on the final cycle of a bit chains the next bit with no gap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      if (cnt == C_LAST) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // bit_val is sampled live so a value written on the start edge is honoured.
  assign bit_done = active && (cnt == C_LAST);
  assign wave     = active && (cnt < (bit_val ? C_T1H : C_T0H));

endmodule
`default_nettype wire

// File: rtl/neo_strand_ctrl_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neo_strand_ctrl_param - framebuffered GRB/GRBW NeoPixel strand controller (rev 1.0)
// ----------------------------------------------------------------------------
module neo_strand_ctrl_param
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS = 5,
  parameter int COLORS     = 3,
  parameter int CH_BITS    = 8,
  parameter int T0H_CYC    = 18,
  parameter int T1H_CYC    = 35,
  parameter int TBIT_CYC   = 63,
  parameter int LATCH_CYC  = 2500,
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PW-1:0]      pixel_index,
  input  logic [1:0]         color_index,
  input  logic [CH_BITS-1:0] color_level,
  input  logic               load_color,
  input  logic               clear_all,
  input  logic               send_it,
  output logic               neo_data,
  output logic               ready_to_load,
  output logic               ready_to_send,
  output logic               busy,
  output logic               done_send,
  output logic               done_wait,
  output logic               load_error
);

  localparam int NBITS = NUM_PIXELS * COLORS * CH_BITS;
  localparam int BW    = $clog2(NBITS);
  localparam int SW    = (CH_BITS > 1) ? $clog2(CH_BITS) : 1;
  localparam int LW    = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);
  localparam logic [SW-1:0] BPOS_TOP   = SW'(CH_BITS - 1);
  localparam logic [1:0]    SLOT_LAST  = 2'(COLORS - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);

  state_t             state;
  state_t             next_state;
  logic               is_idle;

  logic [CH_BITS-1:0] fb [NUM_PIXELS][COLORS];

  logic [PW-1:0]      pix;
  logic [1:0]         slot;
  logic [SW-1:0]      bpos;
  logic [BW-1:0]      bit_idx;
  logic [LW-1:0]      lcnt;

  logic               load_ok;
  logic               enc_start;
  logic               enc_bit;
  logic               enc_wave;
  logic               enc_done;
  logic               last_bit;
  logic               latch_end;

  assign load_ok   = (int'(pixel_index) < NUM_PIXELS) && (int'(color_index) < COLORS);
  assign last_bit  = (state == SEND) && enc_done && (bit_idx == '0);
  assign latch_end = (state == LATCH) && (lcnt == LATCH_LAST);
  assign enc_start = (is_idle && send_it) || ((state == SEND) && enc_done && (bit_idx != '0));
  assign enc_bit   = fb[pix][tx_channel(slot)][bpos];
  assign neo_data  = enc_wave;

  neo_bit_encoder #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_enc (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (enc_start),
    .bit_val  (enc_bit),
    .wave     (enc_wave),
    .bit_done (enc_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (send_it)   next_state = SEND;
      SEND:    if (last_bit)  next_state = LATCH;
      LATCH:   if (latch_end) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_comb begin
    is_idle       = (state == IDLE);
    busy          = (state == SEND) || (state == LATCH);
    ready_to_load = is_idle;
    ready_to_send = is_idle;
  end

  // Writes are only honoured in IDLE, so SEND can read the buffer live.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < COLORS; c++) begin
          fb[p][c] <= '0;
        end
      end
    end else if (is_idle) begin
      if (clear_all) begin
        for (int p = 0; p < NUM_PIXELS; p++) begin
          for (int c = 0; c < COLORS; c++) begin
            fb[p][c] <= '0;
          end
        end
      end else if (load_color && load_ok) begin
        fb[pixel_index][color_index] <= color_level;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx <= BIT_LAST;
      pix     <= '0;
      slot    <= '0;
      bpos    <= BPOS_TOP;
      lcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (send_it) begin
            bit_idx <= BIT_LAST;
            pix     <= '0;
            slot    <= '0;
            bpos    <= BPOS_TOP;
          end
        end
        SEND: begin
          // bit_idx drives the exit; pix/slot/bpos address the buffer.
          if (enc_done && (bit_idx != '0)) begin
            bit_idx <= bit_idx - 1'b1;
            if (bpos == '0) begin
              bpos <= BPOS_TOP;
              if (slot == SLOT_LAST) begin
                slot <= '0;
                pix  <= pix + 1'b1;
              end else begin
                slot <= slot + 1'b1;
              end
            end else begin
              bpos <= bpos - 1'b1;
            end
          end
        end
        LATCH: begin
          lcnt <= latch_end ? '0 : lcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_send  <= 1'b0;
      done_wait  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      done_send  <= last_bit;
      done_wait  <= latch_end;
      load_error <= is_idle && load_color && !clear_all && !load_ok;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neo_strand_ctrl_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_neo_strand_ctrl_param - directed frame checks, 2 pixels GRB, short timing (rev 1.0)
// ----------------------------------------------------------------------------
module tb_neo_strand_ctrl_param;

  logic       clock;
  logic       reset_n;
  logic [0:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       load_color;
  logic       clear_all;
  logic       send_it;
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;
  logic       busy;
  logic       done_send;
  logic       done_wait;
  logic       load_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [47:0] fr_bits;
  int fr_wbad, fr_shape, fr_ds, fr_dsn, fr_dw, fr_busy_low, fr_rdy_bad, fr_lerr;
  logic fr_rdy_end;

  neo_strand_ctrl_param #(
    .NUM_PIXELS (2),
    .COLORS     (3),
    .CH_BITS    (8),
    .T0H_CYC    (2),
    .T1H_CYC    (4),
    .TBIT_CYC   (6),
    .LATCH_CYC  (10)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pixel_index   (pixel_index),
    .color_index   (color_index),
    .color_level   (color_level),
    .load_color    (load_color),
    .clear_all     (clear_all),
    .send_it       (send_it),
    .neo_data      (neo_data),
    .ready_to_load (ready_to_load),
    .ready_to_send (ready_to_send),
    .busy          (busy),
    .done_send     (done_send),
    .done_wait     (done_wait),
    .load_error    (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load(input logic [0:0] p, input logic [1:0] c, input logic [7:0] v,
                      input logic clr, input logic exp_err, input string tag);
    @(posedge clock); #1;
    pixel_index = p; color_index = c; color_level = v; load_color = 1'b1; clear_all = clr;
    @(posedge clock); #1;
    load_color = 1'b0; clear_all = 1'b0;
    @(negedge clock);
    check({tag, "_err"}, load_error, exp_err);
    @(negedge clock);
    check({tag, "_err_next"}, load_error, 1'b0);
  endtask

  // Captures one frame; cycle c counts from the edge that samples send_it.
  task automatic send_frame(input logic with_load, input logic [0:0] p,
                            input logic [1:0] c, input logic [7:0] v);
    int hc [48];
    logic prev;
    int k, j;
    @(posedge clock); #1;
    send_it = 1'b1;
    if (with_load) begin
      pixel_index = p; color_index = c; color_level = v; load_color = 1'b1;
    end
    @(posedge clock); #1;
    send_it = 1'b0; load_color = 1'b0;
    for (int i = 0; i < 48; i++) hc[i] = 0;
    fr_wbad = 0; fr_shape = 0; fr_ds = -1; fr_dsn = 0; fr_dw = -1;
    fr_busy_low = 0; fr_rdy_bad = 0; fr_lerr = 0; fr_rdy_end = 1'b0; prev = 1'b0;
    for (int cyc = 1; cyc <= 320; cyc++) begin
      @(negedge clock);
      if (cyc <= 288) begin
        k = (cyc - 1) / 6;
        j = (cyc - 1) % 6;
        if (neo_data) hc[k]++;
        if (j == 0 && !neo_data) fr_shape++;
        if (j > 0 && neo_data && !prev) fr_shape++;
        prev = neo_data;
      end else if (cyc <= 298 && neo_data) begin
        fr_shape++;
      end
      if (cyc <= 298) begin
        if (!busy) fr_busy_low++;
        if (ready_to_load || ready_to_send) fr_rdy_bad++;
      end
      if (done_send) begin
        fr_dsn++;
        if (fr_ds < 0) fr_ds = cyc;
      end
      if (done_wait && fr_dw < 0) begin
        fr_dw = cyc;
        fr_rdy_end = ready_to_send && !busy;
      end
      if (load_error) fr_lerr++;
    end
    for (int i = 0; i < 48; i++) begin
      fr_bits[47 - i] = (hc[i] == 4);
      if (hc[i] != 2 && hc[i] != 4) fr_wbad++;
    end
  endtask

  task automatic verify_frame(input string tag, input logic [47:0] exp);
    check({tag, "_bits"},    64'(fr_bits), 64'(exp));
    check({tag, "_width"},   64'(fr_wbad), 64'd0);
    check({tag, "_shape"},   64'(fr_shape), 64'd0);
    check({tag, "_dsend"},   64'(fr_ds), 64'd289);
    check({tag, "_dsend_n"}, 64'(fr_dsn), 64'd1);
    check({tag, "_dwait"},   64'(fr_dw), 64'd299);
    check({tag, "_busy"},    64'(fr_busy_low), 64'd0);
    check({tag, "_rdy"},     64'(fr_rdy_bad), 64'd0);
    check({tag, "_rdy_end"}, 64'(fr_rdy_end), 64'd1);
    check({tag, "_lerr"},    64'(fr_lerr), 64'd0);
  endtask

  initial begin
    int pulses;
    reset_n = 1'b0; pixel_index = '0; color_index = '0; color_level = '0;
    load_color = 1'b0; clear_all = 1'b0; send_it = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_neo",   neo_data, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst_pulse", {done_send, done_wait, load_error}, 3'b000);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rdy_load", ready_to_load, 1'b1);
    check("rdy_send", ready_to_send, 1'b1);

    send_frame(1'b0, 1'b0, 2'd0, 8'h00);
    verify_frame("empty", 48'h000000_000000);

    load(1'b0, 2'd0, 8'hFF, 1'b0, 1'b0, "p0r");
    load(1'b0, 2'd1, 8'h00, 1'b0, 1'b0, "p0g");
    load(1'b0, 2'd2, 8'h81, 1'b0, 1'b0, "p0b");
    send_frame(1'b0, 1'b0, 2'd0, 8'h00);
    verify_frame("p0", 48'h00FF81_000000);

    load(1'b1, 2'd3, 8'hAA, 1'b0, 1'b1, "badch");
    send_frame(1'b0, 1'b0, 2'd0, 8'h00);
    verify_frame("after_err", 48'h00FF81_000000);

    fork
      send_frame(1'b0, 1'b0, 2'd0, 8'h00);
      begin
        repeat (60) @(posedge clock); #1;
        pixel_index = 1'b0; color_index = 2'd2; color_level = 8'h00; load_color = 1'b1;
        repeat (2) @(posedge clock); #1;
        load_color = 1'b0; clear_all = 1'b1;
        repeat (2) @(posedge clock); #1;
        clear_all = 1'b0;
      end
    join
    verify_frame("midsend", 48'h00FF81_000000);

    send_frame(1'b1, 1'b1, 2'd2, 8'h01);
    verify_frame("sameclk", 48'h00FF81_000001);

    load(1'b0, 2'd0, 8'h55, 1'b1, 1'b0, "clrld");
    send_frame(1'b0, 1'b0, 2'd0, 8'h00);
    verify_frame("cleared", 48'h000000_000000);

    load(1'b0, 2'd1, 8'hFF, 1'b0, 1'b0, "g0");
    @(posedge clock); #1;
    send_it = 1'b1;
    @(posedge clock); #1;
    send_it = 1'b0;
    repeat (18) @(posedge clock);
    #1;
    check("pre_rst_high", neo_data, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_neo",  neo_data, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clock);
      if (done_send || done_wait) pulses++;
    end
    check("rst_no_done", 64'(pulses), 64'd0);
    send_frame(1'b0, 1'b0, 2'd0, 8'h00);
    verify_frame("post_rst", 48'h000000_000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
